// File: rtl/serial_logic_unit.sv
// serial_logic_unit: multi-cycle bitwise logic engine (AND/OR/XOR/NOR).
// A request latches two WIDTH-bit operands and an opcode, the engine then
// produces the result SLICE bits per clock, and the finished result plus a
// zero flag is offered on a valid/ready response channel.
module serial_logic_unit #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   // WIDTH is expected to be an exact multiple of SLICE; a remainder would
   // leave the top bits of the result unwritten.
   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic [IW-1:0]    sliceBase;
   logic [SLICE-1:0] aSlice;
   logic [SLICE-1:0] bSlice;
   logic [SLICE-1:0] sliceOut;

   // Pick the operand slice addressed by the counter and apply the latched opcode.
   always_comb begin
      sliceBase = IW'(cnt_q) * IW'(SLICE);
      aSlice    = a_q[sliceBase +: SLICE];
      bSlice    = b_q[sliceBase +: SLICE];
      sliceOut  = '0;
      case (op_q)
         OP_AND:  sliceOut = aSlice & bSlice;
         OP_OR:   sliceOut = aSlice | bSlice;
         OP_XOR:  sliceOut = aSlice ^ bSlice;
         OP_NOR:  sliceOut = ~(aSlice | bSlice);
         default: sliceOut = '0;
      endcase
   end

   // Next-state logic: accept in IDLE, write one slice per clock in BUSY,
   // and hold the finished result in DONE until the consumer takes it.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d  = BUSY;
               a_d      = a;
               b_d      = b;
               op_d     = op;
               result_d = '0;
               cnt_d    = '0;
            end
         end
         BUSY: begin
            result_d[sliceBase +: SLICE] = sliceOut;
            if (cnt_q == LAST_SLICE) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
      end
   end

   // Handshake flags come straight from the state register, so neither
   // channel has a combinational path from its partner's input.
   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == DONE);
   assign result     = result_q;
   assign zero       = ~|result_q;

`ifndef SYNTHESIS
   // A pending response must stay put until it is taken.
   property pRespHold;
      @(posedge clk) disable iff (!rst_n)
         (resp_valid && !resp_ready) |=> (resp_valid && $stable(result));
   endproperty
   aRespHold: assert property (pRespHold);

   // Accept and response are mutually exclusive by construction.
   property pNoOverlap;
      @(posedge clk) disable iff (!rst_n)
         !(req_ready && resp_valid);
   endproperty
   aNoOverlap: assert property (pNoOverlap);
`endif

endmodule
